// File: rtl/inst_fetcher_if.sv
// inst_fetcher_if: icache, branch-predictor, issuer and ROB-bus signals of the fetch stage
interface inst_fetcher_if;
  logic        valid_to_icache;
  logic [31:0] addr_to_icache;
  logic        valid_from_icache;
  logic [31:0] inst_from_icache;
  logic [31:0] inst_to_br_predictor;
  logic [31:0] pc_to_br_predictor;
  logic [31:0] next_pc_from_br_predictor;
  logic        valid_to_issuer;
  logic [31:0] inst_to_issuer;
  logic [31:0] pc_to_issuer;
  logic [31:0] pred_pc_to_issuer;
  logic        ready_from_issuer;
  logic        reset_from_rob_bus;
  logic [31:0] target_pc_from_rob_bus;
  modport master (
    output valid_to_icache, addr_to_icache, inst_to_br_predictor, pc_to_br_predictor,
           valid_to_issuer, inst_to_issuer, pc_to_issuer, pred_pc_to_issuer,
    input  valid_from_icache, inst_from_icache, next_pc_from_br_predictor,
           ready_from_issuer, reset_from_rob_bus, target_pc_from_rob_bus
  );
  modport slave (
    input  valid_to_icache, addr_to_icache, inst_to_br_predictor, pc_to_br_predictor,
           valid_to_issuer, inst_to_issuer, pc_to_issuer, pred_pc_to_issuer,
    output valid_from_icache, inst_from_icache, next_pc_from_br_predictor,
           ready_from_issuer, reset_from_rob_bus, target_pc_from_rob_bus
  );
endinterface

// File: rtl/inst_fetcher.sv
// inst_fetcher: owns the fetch PC, keeps one icache request in flight and queues fetched words
module inst_fetcher #(
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter int          QUEUE_DEPTH_LOG = 4
) (
  input logic            clk,
  input logic            rst,
  input logic            rdy,
  inst_fetcher_if.master bus
);
  localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
  localparam logic [QUEUE_DEPTH_LOG:0] FULL = (QUEUE_DEPTH_LOG+1)'(DEPTH);
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;
  state_t                     r_state, w_next;
  logic [31:0]                r_pc, r_addr, w_pc;
  logic                       r_req;
  logic [95:0]                r_mem [DEPTH];
  logic [QUEUE_DEPTH_LOG-1:0] r_head, r_tail;
  logic [QUEUE_DEPTH_LOG:0]   r_count;
  logic                       w_flush, w_resp, w_full, w_req, w_push, w_pop;
  assign w_flush = bus.reset_from_rob_bus;
  assign w_resp  = bus.valid_from_icache;
  assign w_full  = r_count == FULL;
  // State register, frozen while rdy is low
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= FETCH;
    else if (rdy) r_state <= w_next;
  // Next state: a response always ends WAIT/DROP; a flush without response in WAIT must drop it later
  always_comb begin
    w_next = r_state;
    if (r_state == FETCH) w_next = (w_flush || w_full) ? FETCH : WAIT;
    else if (w_resp) w_next = FETCH;
    else if (w_flush) w_next = DROP;
  end
  // Decoded actions for this cycle; flush overrides request, push and pop
  always_comb begin
    w_req  = r_state == FETCH && !w_flush && !w_full;
    w_push = r_state == WAIT && w_resp && !w_flush;
    w_pop  = bus.valid_to_issuer && bus.ready_from_issuer && !w_flush;
    w_pc   = w_flush ? bus.target_pc_from_rob_bus : w_push ? bus.next_pc_from_br_predictor : r_pc;
  end
  // PC, request pulse and queue pointers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      r_pc    <= w_pc;
      r_req   <= w_req;
      r_addr  <= w_req ? r_pc : r_addr;
      r_head  <= w_flush ? '0 : r_head + QUEUE_DEPTH_LOG'(w_pop);
      r_tail  <= w_flush ? '0 : r_tail + QUEUE_DEPTH_LOG'(w_push);
      r_count <= w_flush ? '0 : r_count + (QUEUE_DEPTH_LOG+1)'(w_push) - (QUEUE_DEPTH_LOG+1)'(w_pop);
    end
  // Queue storage: {inst, pc, predicted next pc}
  always_ff @(posedge clk)
    if (rdy && w_push) r_mem[r_tail] <= {bus.inst_from_icache, r_pc, bus.next_pc_from_br_predictor};
  assign bus.valid_to_icache      = r_req;
  assign bus.addr_to_icache       = r_addr;
  assign bus.inst_to_br_predictor = bus.inst_from_icache;
  assign bus.pc_to_br_predictor   = r_pc;
  assign bus.valid_to_issuer      = r_count != '0;
  assign {bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer} = r_mem[r_head];
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: directed and randomized fetch/flush/stall traffic checked against a queue-based model
module tb_inst_fetcher;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b0;
  inst_fetcher_if bus();
  inst_fetcher dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] inst, pc, pred;} ent_t;
  ent_t        m_q[$];
  logic        m_out, m_drop, m_req;
  logic [31:0] m_pc, m_addr;
  int          checks = 0, errors = 0;
  logic        ic_pend = 1'b0, force_en = 1'b0, rnd = 1'b0;
  int          ic_lat = 0, lat_min = 1, lat_max = 1, fl_mod = 16, rd_mod = 3;
  logic [31:0] ic_addr = 32'h0, force_inst = 32'h0;
  logic        s_vreq, s_vis;
  logic [31:0] s_addr;
  ent_t        s_head;
  logic [31:0] req_log[$];
  ent_t        pop_log[$];

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a[5:0] == 6'h10 ? 32'h0300006f : {a[26:2], 7'h13};
  endfunction
  function automatic logic [31:0] pred(input logic [31:0] i, input logic [31:0] p);
    return i[6:0] == 7'h6f ? p + 32'h30 : p + 32'h4;
  endfunction
  assign bus.next_pc_from_br_predictor = pred(bus.inst_to_br_predictor, bus.pc_to_br_predictor);

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_req  = 1'b0;
    m_pc   = 32'h0;
    m_addr = 32'h0;
  endfunction

  // Reference: one outstanding request, discard flag, queue of fetched entries
  task automatic m_step();
    logic fl, rs, full;
    ent_t e;
    fl = bus.reset_from_rob_bus;
    rs = bus.valid_from_icache;
    full = m_q.size() == 16;
    if (!fl && bus.ready_from_issuer && m_q.size() != 0) e = m_q.pop_front();
    m_req = 1'b0;
    if (!m_out) begin
      if (fl) m_pc = bus.target_pc_from_rob_bus;
      else if (!full) begin
        m_req = 1'b1; m_addr = m_pc; m_out = 1'b1; m_drop = 1'b0;
      end
    end else if (rs) begin
      if (fl) m_pc = bus.target_pc_from_rob_bus;
      else if (!m_drop) begin
        e.inst = bus.inst_from_icache;
        e.pc   = m_pc;
        e.pred = pred(bus.inst_from_icache, m_pc);
        m_q.push_back(e);
        m_pc = e.pred;
      end
      m_out = 1'b0;
    end else if (fl) begin
      m_pc = bus.target_pc_from_rob_bus;
      m_drop = 1'b1;
    end
    if (fl) m_q.delete();
  endtask

  // One clock: sample at negedge, advance model and icache at posedge, drive inputs 1 ns later
  task automatic tick();
    logic nv;
    logic [31:0] ni;
    @(negedge clk);
    s_vreq = bus.valid_to_icache;
    s_addr = bus.addr_to_icache;
    s_vis  = bus.valid_to_issuer;
    s_head = '{bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer};
    if (rst && s_vreq) req_log.push_back(s_addr);
    @(posedge clk);
    nv = bus.valid_from_icache;
    ni = bus.inst_from_icache;
    if (!rst) ic_pend = 1'b0;
    else if (rdy) begin
      if (s_vis && bus.ready_from_issuer && !bus.reset_from_rob_bus) pop_log.push_back(s_head);
      m_step();
      nv = 1'b0;
      if (s_vreq) begin
        ic_pend = 1'b1; ic_addr = s_addr; ic_lat = $urandom_range(lat_max, lat_min);
      end
      if (ic_pend) begin
        if (ic_lat <= 1) begin
          nv = 1'b1; ni = force_en ? force_inst : imem(ic_addr); ic_pend = 1'b0;
        end else ic_lat--;
      end
    end
    #1;
    bus.valid_from_icache = nv;
    bus.inst_from_icache  = ni;
    if (rnd) begin
      rdy = $urandom_range(0, 7) != 0;
      bus.ready_from_issuer  = $urandom_range(0, rd_mod - 1) == 0;
      bus.reset_from_rob_bus = $urandom_range(0, fl_mod - 1) == 0;
      bus.target_pc_from_rob_bus = 32'($urandom_range(0, 255)) << 2;
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid_to_icache", bus.valid_to_icache, 0);
      chk("rst_addr_to_icache", bus.addr_to_icache, 0);
      chk("rst_valid_to_issuer", bus.valid_to_issuer, 0);
    end else begin
      chk("valid_to_icache", bus.valid_to_icache, m_req);
      chk("addr_to_icache", bus.addr_to_icache, m_addr);
      chk("pc_to_br_predictor", bus.pc_to_br_predictor, m_pc);
      chk("inst_to_br_predictor", bus.inst_to_br_predictor, bus.inst_from_icache);
      chk("valid_to_issuer", bus.valid_to_issuer, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("inst_to_issuer", bus.inst_to_issuer, m_q[0].inst);
        chk("pc_to_issuer", bus.pc_to_issuer, m_q[0].pc);
        chk("pred_pc_to_issuer", bus.pred_pc_to_issuer, m_q[0].pred);
      end
    end
  end

  initial begin
    int n, n1, pl, k;
    logic hit;
    bus.valid_from_icache = 1'b0;
    bus.inst_from_icache = 32'h0;
    bus.ready_from_issuer = 1'b0;
    bus.reset_from_rob_bus = 1'b0;
    bus.target_pc_from_rob_bus = 32'h0;
    #1 rst = 1'b0;
    m_reset();
    repeat (3) tick();
    // Sequential fetch, then a jal at 0x10 predicted to 0x40
    rst = 1'b1; rdy = 1'b1; bus.ready_from_issuer = 1'b1;
    repeat (30) tick();
    chk("t1_nreq", req_log.size() >= 6, 1);
    chk("t1_npop", pop_log.size() >= 5, 1);
    if (req_log.size() >= 6 && pop_log.size() >= 5) begin
      chk("t1_req0", req_log[0], 32'h0);
      chk("t1_req1", req_log[1], 32'h4);
      chk("t1_req2", req_log[2], 32'h8);
      chk("t1_pop0_pc", pop_log[0].pc, 32'h0);
      chk("t1_pop0_pred", pop_log[0].pred, 32'h4);
      chk("t1_pop2_pc", pop_log[2].pc, 32'h8);
      chk("t1_pop2_pred", pop_log[2].pred, 32'hC);
      chk("t2_jal_pc", pop_log[4].pc, 32'h10);
      chk("t2_jal_pred", pop_log[4].pred, 32'h40);
      chk("t2_req_after_jal", req_log[5], 32'h40);
    end
    // Fill the queue with the issuer stalled
    bus.ready_from_issuer = 1'b0;
    bus.reset_from_rob_bus = 1'b1; bus.target_pc_from_rob_bus = 32'h100;
    tick();
    bus.reset_from_rob_bus = 1'b0;
    n = req_log.size(); pl = pop_log.size();
    repeat (70) tick();
    n1 = req_log.size();
    chk("t3_sixteen_requests", n1 - n, 16);
    repeat (20) tick();
    chk("t3_no_request_when_full", req_log.size(), n1);
    bus.ready_from_issuer = 1'b1; tick(); bus.ready_from_issuer = 1'b0;
    repeat (10) tick();
    chk("t3_one_request_after_pop", req_log.size(), n1 + 1);
    if (req_log.size() > n1) chk("t3_req_after_pop", req_log[n1], 32'h1C4);
    bus.ready_from_issuer = 1'b1;
    repeat (60) tick();
    chk("t3_npop", pop_log.size() >= pl + 17, 1);
    if (pop_log.size() >= pl + 17) begin
      chk("t3_first_pc", pop_log[pl].pc, 32'h100);
      chk("t3_first_pred", pop_log[pl].pred, 32'h104);
      chk("t3_jal_pred", pop_log[pl + 4].pred, 32'h140);
      chk("t3_wrap_pc", pop_log[pl + 16].pc, 32'h1C4);
    end
    // Flush in WAIT, stale response one cycle later
    lat_min = 2; lat_max = 2; force_en = 1'b1; force_inst = 32'hDEADBEEF;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin tick(); hit = s_vreq; end
    if (!hit) begin errors++; checks++; $display("FAIL t4_timeout no request seen"); end
    bus.reset_from_rob_bus = 1'b1; bus.target_pc_from_rob_bus = 32'h200;
    tick();
    bus.reset_from_rob_bus = 1'b0;
    n = req_log.size();
    tick();
    chk("t4_queue_empty", bus.valid_to_issuer, 0);
    force_en = 1'b0; lat_min = 1; lat_max = 1;
    repeat (10) tick();
    chk("t4_nreq", req_log.size() > n, 1);
    if (req_log.size() > n) chk("t4_req_target", req_log[n], 32'h200);
    k = 0;
    foreach (pop_log[i]) if (pop_log[i].inst == 32'hDEADBEEF) k++;
    chk("t4_no_deadbeef", k, 0);
    // Flush coinciding with a response and a pop, three entries queued
    bus.ready_from_issuer = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin tick(); hit = m_q.size() == 3 && bus.valid_from_icache; end
    if (!hit) begin errors++; checks++; $display("FAIL t5_timeout queue never reached 3"); end
    chk("t5_three_queued", bus.valid_to_issuer, 1);
    bus.reset_from_rob_bus = 1'b1; bus.target_pc_from_rob_bus = 32'h300; bus.ready_from_issuer = 1'b1;
    tick();
    bus.reset_from_rob_bus = 1'b0;
    chk("t5_queue_empty", bus.valid_to_issuer, 0);
    n = req_log.size();
    repeat (4) tick();
    chk("t5_nreq", req_log.size() > n, 1);
    if (req_log.size() > n) chk("t5_req_target", req_log[n], 32'h300);
    // Asynchronous reset while a request is outstanding
    bus.ready_from_issuer = 1'b0;
    repeat (7) tick();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin tick(); hit = bus.valid_to_icache; end
    if (!hit) begin errors++; checks++; $display("FAIL t6_timeout no request seen"); end
    chk("t6_queue_nonempty", bus.valid_to_issuer, 1);
    #2 rst = 1'b0;
    m_reset();
    #1;
    chk("t6_async_valid", bus.valid_to_icache, 0);
    chk("t6_async_addr", bus.addr_to_icache, 0);
    chk("t6_async_issuer", bus.valid_to_issuer, 0);
    bus.valid_from_icache = 1'b1; bus.inst_from_icache = 32'hBAD0BAD0;
    tick(); tick();
    bus.valid_from_icache = 1'b0;
    rst = 1'b1; bus.ready_from_issuer = 1'b1;
    n = req_log.size();
    repeat (4) tick();
    chk("t6_nreq", req_log.size() > n, 1);
    if (req_log.size() > n) chk("t6_req_reset_pc", req_log[n], 32'h0);
    // Randomized traffic: frequent flushes, then rare flushes with a slow issuer
    lat_min = 1; lat_max = 3; rnd = 1'b1;
    repeat (2500) tick();
    fl_mod = 200; rd_mod = 4;
    repeat (2500) tick();
    rnd = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
